// File: rtl/store_checker.sv
// Store checker: compares bus stores against a table of expected {address, data} pairs.
// Tracks per-entry pass/fail, first mismatch, and an optional run timeout.
//
// state  | meaning
// S_IDLE | table may be loaded, stores ignored, waiting for start
// S_RUN  | stores compared against unresolved entries, timeout counting
// S_DONE | all entries resolved or timed out; held until reset
module store_checker #(
  parameter int NUM_CHECKS     = 4,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int REWRITE_CHECK  = 0,
  localparam int IDX_W = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1,
  localparam int CNT_W = $clog2(NUM_CHECKS + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_we,
  input  logic [IDX_W-1:0]      cfg_idx,
  input  logic [ADDR_W-1:0]     cfg_addr,
  input  logic [DATA_W-1:0]     cfg_data,
  input  logic                  start,
  input  logic                  memwrite,
  input  logic [ADDR_W-1:0]     dataadr,
  input  logic [DATA_W-1:0]     writedata,
  output logic                  done,
  output logic                  pass,
  output logic                  error,
  output logic                  timeout,
  output logic [NUM_CHECKS-1:0] pass_vec,
  output logic [NUM_CHECKS-1:0] fail_vec,
  output logic [CNT_W-1:0]      pass_count,
  output logic [CNT_W-1:0]      fail_count,
  output logic [IDX_W-1:0]      first_fail_idx,
  output logic [DATA_W-1:0]     first_fail_data
);

  localparam int TO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                r_state, w_state_nxt;
  logic [ADDR_W-1:0]     r_exp_addr [NUM_CHECKS];
  logic [DATA_W-1:0]     r_exp_data [NUM_CHECKS];
  logic [NUM_CHECKS-1:0] r_pass_vec, r_fail_vec;
  logic [CNT_W-1:0]      r_pass_cnt, r_fail_cnt;
  logic                  r_error, r_timeout;
  logic [IDX_W-1:0]      r_ffi;
  logic [DATA_W-1:0]     r_ffd;
  logic [TO_W-1:0]       r_tcnt;

  logic                  w_hit_open, w_hit_res;
  logic [IDX_W-1:0]      w_open_idx, w_res_idx;
  logic                  w_store, w_cfg, w_to_hit, w_all, w_mismatch, w_done;
  logic [IDX_W-1:0]      w_mis_idx;
  logic [NUM_CHECKS-1:0] w_pass_nxt, w_fail_nxt;

  function automatic logic [CNT_W-1:0] popcnt(input logic [NUM_CHECKS-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_CHECKS; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  // Descending scan so the lowest matching index is the one that survives.
  always_comb begin
    w_hit_open = 1'b0;
    w_hit_res  = 1'b0;
    w_open_idx = '0;
    w_res_idx  = '0;
    for (int i = NUM_CHECKS - 1; i >= 0; i--) begin
      if (r_exp_addr[i] == dataadr) begin
        if (!(r_pass_vec[i] | r_fail_vec[i])) begin
          w_hit_open = 1'b1;
          w_open_idx = IDX_W'(i);
        end else begin
          w_hit_res = 1'b1;
          w_res_idx = IDX_W'(i);
        end
      end
    end
  end

  assign w_store  = (r_state == S_RUN) && memwrite;
  assign w_cfg    = cfg_we && (r_state != S_DONE) && (int'(cfg_idx) < NUM_CHECKS);
  assign w_to_hit = (TIMEOUT_CYCLES != 0) && (r_state == S_RUN) &&
                    ((r_tcnt + TO_W'(1)) == TO_MAX);

  // Comparisons use the table as registered, so a same-cycle config write is not seen.
  always_comb begin
    w_pass_nxt = r_pass_vec;
    w_fail_nxt = r_fail_vec;
    w_mismatch = 1'b0;
    w_mis_idx  = '0;
    if (w_store) begin
      if (w_hit_open) begin
        if (writedata == r_exp_data[w_open_idx]) begin
          w_pass_nxt[w_open_idx] = 1'b1;
        end else begin
          w_fail_nxt[w_open_idx] = 1'b1;
          w_mismatch = 1'b1;
          w_mis_idx  = w_open_idx;
        end
      end else if ((REWRITE_CHECK != 0) && w_hit_res &&
                   (writedata != r_exp_data[w_res_idx])) begin
        w_pass_nxt[w_res_idx] = 1'b0;
        w_fail_nxt[w_res_idx] = 1'b1;
        w_mismatch = 1'b1;
        w_mis_idx  = w_res_idx;
      end
    end
    if (w_cfg) begin
      w_pass_nxt[cfg_idx] = 1'b0;
      w_fail_nxt[cfg_idx] = 1'b0;
    end
  end

  assign w_all = &(w_pass_nxt | w_fail_nxt);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_all || w_to_hit) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_done          = (r_state == S_DONE);
    done            = w_done;
    pass            = w_done & ~r_error & ~r_timeout;
    error           = r_error;
    timeout         = r_timeout;
    pass_vec        = r_pass_vec;
    fail_vec        = r_fail_vec;
    pass_count      = r_pass_cnt;
    fail_count      = r_fail_cnt;
    first_fail_idx  = r_ffi;
    first_fail_data = r_ffd;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CHECKS; i++) begin
        r_exp_addr[i] <= '0;
        r_exp_data[i] <= '0;
      end
      r_pass_vec <= '0;
      r_fail_vec <= '0;
      r_pass_cnt <= '0;
      r_fail_cnt <= '0;
      r_error    <= 1'b0;
      r_timeout  <= 1'b0;
      r_ffi      <= '0;
      r_ffd      <= '0;
      r_tcnt     <= '0;
    end else begin
      if (w_cfg) begin
        r_exp_addr[cfg_idx] <= cfg_addr;
        r_exp_data[cfg_idx] <= cfg_data;
      end
      r_pass_vec <= w_pass_nxt;
      r_fail_vec <= w_fail_nxt;
      r_pass_cnt <= popcnt(w_pass_nxt);
      r_fail_cnt <= popcnt(w_fail_nxt);
      if (w_mismatch && !r_error) begin
        r_error <= 1'b1;
        r_ffi   <= w_mis_idx;
        r_ffd   <= writedata;
      end
      if (w_to_hit) r_timeout <= 1'b1;
      if ((r_state == S_IDLE) && start) r_tcnt <= '0;
      else if ((r_state == S_RUN) && (r_tcnt != TO_MAX)) r_tcnt <= r_tcnt + TO_W'(1);
    end
  end

endmodule

// File: tb/tb_store_checker.sv
// Directed bench for store_checker: instance A (timeout 10, no rewrite check) and
// instance B (timeout disabled, rewrite check on) share one stimulus stream.
module tb_store_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b0, cfg_we = 1'b0, start = 1'b0, memwrite = 1'b0;
  logic [1:0]  cfg_idx = '0;
  logic [31:0] cfg_addr = '0, cfg_data = '0, dataadr = '0, writedata = '0;

  logic        a_done, a_pass, a_error, a_timeout;
  logic [3:0]  a_pv, a_fv;
  logic [2:0]  a_pc, a_fc;
  logic [1:0]  a_ffi;
  logic [31:0] a_ffd;
  logic        b_done, b_pass, b_error, b_timeout;
  logic [3:0]  b_pv, b_fv;
  logic [2:0]  b_pc, b_fc;
  logic [1:0]  b_ffi;
  logic [31:0] b_ffd;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  store_checker #(.NUM_CHECKS(4), .ADDR_W(32), .DATA_W(32),
                  .TIMEOUT_CYCLES(10), .REWRITE_CHECK(0)) u_a (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .start(start),
    .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
    .done(a_done), .pass(a_pass), .error(a_error), .timeout(a_timeout),
    .pass_vec(a_pv), .fail_vec(a_fv), .pass_count(a_pc), .fail_count(a_fc),
    .first_fail_idx(a_ffi), .first_fail_data(a_ffd));

  store_checker #(.NUM_CHECKS(4), .ADDR_W(32), .DATA_W(32),
                  .TIMEOUT_CYCLES(0), .REWRITE_CHECK(1)) u_b (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .start(start),
    .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
    .done(b_done), .pass(b_pass), .error(b_error), .timeout(b_timeout),
    .pass_vec(b_pv), .fail_vec(b_fv), .pass_count(b_pc), .fail_count(b_fc),
    .first_fail_idx(b_ffi), .first_fail_data(b_ffd));

  // Packed output image: {done,pass,error,timeout,pass_vec,fail_vec,pass_cnt,fail_cnt,ffi,ffd}
  function automatic logic [51:0] mk(input logic d, p, e, t, input logic [3:0] pv, fv,
                                     input logic [2:0] pc, fc, input logic [1:0] fi,
                                     input logic [31:0] fd);
    return {d, p, e, t, pv, fv, pc, fc, fi, fd};
  endfunction

  function automatic logic [51:0] got_a();
    return {a_done, a_pass, a_error, a_timeout, a_pv, a_fv, a_pc, a_fc, a_ffi, a_ffd};
  endfunction

  function automatic logic [51:0] got_b();
    return {b_done, b_pass, b_error, b_timeout, b_pv, b_fv, b_pc, b_fc, b_ffi, b_ffd};
  endfunction

  task automatic check(input string name, input logic [51:0] act, input logic [51:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst, st, we;
    logic [1:0]  idx;
    logic [31:0] ca, cd;
    logic        mw;
    logic [31:0] da, wd;
    logic [51:0] exp;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic rst, st, we, input logic [1:0] idx,
                     input logic [31:0] ca, cd, input logic mw,
                     input logic [31:0] da, wd, input logic [51:0] exp);
    vec_t v;
    v.rst = rst; v.st = st; v.we = we; v.idx = idx; v.ca = ca; v.cd = cd;
    v.mw = mw; v.da = da; v.wd = wd; v.exp = exp;
    tv.push_back(v);
  endtask

  task automatic step(input logic rst, st, we, input logic [1:0] idx,
                      input logic [31:0] ca, cd, input logic mw,
                      input logic [31:0] da, wd);
    reset = rst; start = st; cfg_we = we; cfg_idx = idx;
    cfg_addr = ca; cfg_data = cd; memwrite = mw; dataadr = da; writedata = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic do_rst();               step(1, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic do_go();                step(0, 1, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic do_idle();              step(0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic do_cfg(input logic [1:0] i, input logic [31:0] a, d);
    step(0, 0, 1, i, a, d, 0, 0, 0);
  endtask
  task automatic do_st(input logic [31:0] a, d);
    step(0, 0, 0, 0, 0, 0, 1, a, d);
  endtask
  task automatic load_std();
    do_cfg(0, 200, 32'h1);
    do_cfg(1, 204, 32'hFFFF_FFFF);
    do_cfg(2, 208, 32'h64);
    do_cfg(3, 212, 32'hC8);
  endtask

  logic [51:0] z;

  initial begin
    z = mk(0, 0, 0, 0, 4'b0, 4'b0, 0, 0, 0, 0);

    // Full-pass run, idle-store ignore, unmatched store, reset with start/memwrite.
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, z);
    add(0, 0, 1, 0, 200, 32'h1, 0, 0, 0, z);
    add(0, 0, 1, 1, 204, 32'hFFFF_FFFF, 0, 0, 0, z);
    add(0, 0, 1, 2, 208, 32'h64, 0, 0, 0, z);
    add(0, 0, 1, 3, 212, 32'hC8, 0, 0, 0, z);
    add(0, 0, 0, 0, 0, 0, 1, 200, 32'h1, z);
    add(0, 1, 0, 0, 0, 0, 0, 0, 0, z);
    add(0, 0, 0, 0, 0, 0, 1, 100, 32'h5, z);
    add(0, 0, 0, 0, 0, 0, 1, 200, 32'h1, mk(0, 0, 0, 0, 4'b0001, 0, 1, 0, 0, 0));
    add(0, 0, 0, 0, 0, 0, 1, 204, 32'hFFFF_FFFF, mk(0, 0, 0, 0, 4'b0011, 0, 2, 0, 0, 0));
    add(0, 0, 0, 0, 0, 0, 1, 208, 32'h64, mk(0, 0, 0, 0, 4'b0111, 0, 3, 0, 0, 0));
    add(0, 0, 0, 0, 0, 0, 1, 212, 32'hC8, mk(1, 1, 0, 0, 4'b1111, 0, 4, 0, 0, 0));
    add(0, 0, 0, 0, 0, 0, 1, 200, 32'h9, mk(1, 1, 0, 0, 4'b1111, 0, 4, 0, 0, 0));
    add(1, 1, 0, 0, 0, 0, 1, 0, 0, z);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0, z);
    // Mismatch run: first failure latched, later failure does not overwrite it.
    add(0, 0, 1, 0, 200, 32'h1, 0, 0, 0, z);
    add(0, 0, 1, 1, 204, 32'hFFFF_FFFF, 0, 0, 0, z);
    add(0, 0, 1, 2, 208, 32'h64, 0, 0, 0, z);
    add(0, 0, 1, 3, 212, 32'hC8, 0, 0, 0, z);
    add(0, 1, 0, 0, 0, 0, 0, 0, 0, z);
    add(0, 0, 0, 0, 0, 0, 1, 208, 32'h65, mk(0, 0, 1, 0, 0, 4'b0100, 0, 1, 2, 32'h65));
    add(0, 0, 0, 0, 0, 0, 1, 200, 32'h7, mk(0, 0, 1, 0, 0, 4'b0101, 0, 2, 2, 32'h65));
    add(0, 0, 0, 0, 0, 0, 1, 204, 32'hFFFF_FFFF,
        mk(0, 0, 1, 0, 4'b0010, 4'b0101, 1, 2, 2, 32'h65));
    add(0, 0, 0, 0, 0, 0, 1, 212, 32'hC8,
        mk(1, 0, 1, 0, 4'b1010, 4'b0101, 2, 2, 2, 32'h65));

    #2;
    for (int i = 0; i < tv.size(); i++) begin
      step(tv[i].rst, tv[i].st, tv[i].we, tv[i].idx, tv[i].ca, tv[i].cd,
           tv[i].mw, tv[i].da, tv[i].wd);
      check($sformatf("vec%0d_a", i), got_a(), tv[i].exp);
      check($sformatf("vec%0d_b", i), got_b(), tv[i].exp);
    end

    // Rewrite of a resolved entry: only B re-checks it.
    do_rst();
    load_std();
    do_go();
    do_st(200, 32'h1);
    check("rw_first_a", got_a(), mk(0, 0, 0, 0, 4'b0001, 0, 1, 0, 0, 0));
    do_st(200, 32'h2);
    check("rw_ignored_a", got_a(), mk(0, 0, 0, 0, 4'b0001, 0, 1, 0, 0, 0));
    check("rw_moved_b", got_b(), mk(0, 0, 1, 0, 4'b0000, 4'b0001, 0, 1, 0, 32'h2));
    do_st(200, 32'h1);
    check("rw_same_b", got_b(), mk(0, 0, 1, 0, 4'b0000, 4'b0001, 0, 1, 0, 32'h2));

    // Duplicate addresses resolve lowest unresolved first; same-cycle cfg uses old table.
    do_rst();
    do_cfg(0, 300, 32'hA);
    do_cfg(1, 300, 32'hB);
    do_cfg(2, 304, 32'h0);
    do_cfg(3, 308, 32'h0);
    do_go();
    do_st(300, 32'hB);
    check("dup_low_a", got_a(), mk(0, 0, 1, 0, 0, 4'b0001, 0, 1, 0, 32'hB));
    do_st(300, 32'hB);
    check("dup_next_a", got_a(), mk(0, 0, 1, 0, 4'b0010, 4'b0001, 1, 1, 0, 32'hB));
    step(0, 0, 1, 3, 312, 32'h1, 1, 312, 32'h1);
    check("cfg_same_cyc_a", got_a(), mk(0, 0, 1, 0, 4'b0010, 4'b0001, 1, 1, 0, 32'hB));
    do_st(312, 32'h1);
    check("cfg_new_entry_a", got_a(), mk(0, 0, 1, 0, 4'b1010, 4'b0001, 2, 1, 0, 32'hB));
    do_st(304, 32'h0);
    check("dup_done_a", got_a(), mk(1, 0, 1, 0, 4'b1110, 4'b0001, 3, 1, 0, 32'hB));
    check("dup_done_b", got_b(), mk(1, 0, 1, 0, 4'b1110, 4'b0001, 3, 1, 0, 32'hB));

    // Timeout after exactly 10 RUN cycles on A; B has it disabled.
    do_rst();
    do_go();
    for (int i = 0; i < 9; i++) do_idle();
    check("to_before_a", got_a(), z);
    do_idle();
    check("to_fire_a", got_a(), mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    check("to_off_b", got_b(), z);
    for (int i = 0; i < 3; i++) do_idle();
    check("to_hold_a", got_a(), mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    check("to_off_hold_b", got_b(), z);

    // Reset mid-run, then reload and a clean pass.
    do_rst();
    load_std();
    do_go();
    do_st(200, 32'h1);
    do_st(204, 32'hFFFF_FFFF);
    check("mid_two_a", got_a(), mk(0, 0, 0, 0, 4'b0011, 0, 2, 0, 0, 0));
    do_rst();
    check("mid_rst_a", got_a(), z);
    check("mid_rst_b", got_b(), z);
    load_std();
    do_go();
    do_st(212, 32'hC8);
    do_st(208, 32'h64);
    do_st(204, 32'hFFFF_FFFF);
    check("rerun_three_a", got_a(), mk(0, 0, 0, 0, 4'b1110, 0, 3, 0, 0, 0));
    do_st(200, 32'h1);
    check("rerun_done_a", got_a(), mk(1, 1, 0, 0, 4'b1111, 0, 4, 0, 0, 0));
    check("rerun_done_b", got_b(), mk(1, 1, 0, 0, 4'b1111, 0, 4, 0, 0, 0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
